// File: rtl/mr1_mem_arbiter.sv
// Shares one memory request/response port between the MR1 fetch and data channels.
// Optional macro MR1_MEM_ARB_RR_EN selects round-robin arbitration instead of data-over-instr priority.
module mr1_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req_valid,
    output logic              instr_req_ready,
    input  logic [ADDR_W-1:0] instr_req_addr,
    output logic              instr_rsp_valid,
    output logic [31:0]       instr_rsp_data,
    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic              data_req_wr,
    input  logic [3:0]        data_req_be,
    input  logic [31:0]       data_req_data,
    output logic              data_rsp_valid,
    output logic [31:0]       data_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wr,
    output logic [3:0]        mem_req_be,
    output logic [31:0]       mem_req_data,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              rsp_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK_INSTR,
        ST_LOCK_DATA
    } state_t;

    state_t             state, state_next;
    logic               sel_data;
    logic               win_valid;
    logic               full;
    logic               accept;
    logic               push;
    logic               pop;
    logic               unmatched;
    logic               rsp_src;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               tag_mem [MAX_OUTSTANDING];

`ifdef MR1_MEM_ARB_RR_EN
    // 1 = data was granted last; reset value lets instr win the first contention.
    logic last_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_data <= 1'b1;
        end else if (accept) begin
            last_data <= sel_data;
        end
    end
`endif

    // Winner selection: a lock forces the locked source regardless of the other requester.
    always_comb begin
        sel_data  = 1'b0;
        win_valid = 1'b0;
        case (state)
            ST_LOCK_INSTR: begin
                sel_data  = 1'b0;
                win_valid = instr_req_valid;
            end
            ST_LOCK_DATA: begin
                sel_data  = 1'b1;
                win_valid = data_req_valid;
            end
            default: begin
`ifdef MR1_MEM_ARB_RR_EN
                if (instr_req_valid && data_req_valid) begin
                    sel_data = !last_data;
                end else begin
                    sel_data = data_req_valid;
                end
`else
                sel_data = data_req_valid;
`endif
                win_valid = instr_req_valid || data_req_valid;
            end
        endcase
    end

    assign full          = (count == MAX_CNT);
    assign mem_req_valid = reset && win_valid && !full;
    assign accept        = mem_req_valid && mem_req_ready;
    assign mem_req_addr  = sel_data ? data_req_addr : instr_req_addr;
    assign mem_req_wr    = sel_data && data_req_wr;
    assign mem_req_be    = sel_data ? data_req_be : 4'hf;
    assign mem_req_data  = sel_data ? data_req_data : 32'h0;

    assign instr_req_ready = accept && !sel_data;
    assign data_req_ready  = accept && sel_data;

    // Valid/ready: a request transfers in any cycle where both are high; requesters hold payload until then.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mem_req_valid && !mem_req_ready) begin
                    state_next = sel_data ? ST_LOCK_DATA : ST_LOCK_INSTR;
                end
            end
            ST_LOCK_INSTR, ST_LOCK_DATA: begin
                if (accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign push      = accept && !mem_req_wr;
    assign pop       = reset && mem_rsp_valid && (count != '0);
    assign unmatched = reset && mem_rsp_valid && (count == '0);
    assign rsp_src   = tag_mem[rd_ptr];

    assign instr_rsp_valid = pop && !rsp_src;
    assign data_rsp_valid  = pop && rsp_src;
    assign instr_rsp_data  = mem_rsp_data;
    assign data_rsp_data   = mem_rsp_data;

    // Pointers are power-of-two wide, so natural overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (unmatched) begin
                rsp_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= sel_data;
        end
    end

endmodule
